pipeline_control: RTL and testbench
===================================

# pipeline_control

Sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It takes the ID-stage hazard flag, EX-stage branch/jump resolution and the ID-stage halt decode, and drives every pipeline-register enable, flush and bubble signal. It also drains the pipeline on halt, bounds stall length with a watchdog, and keeps cycle, stall and flush counters. It replaces the ad-hoc stall/nop/halt glue in the top level.

## Interface
- `STALL_LIMIT`, 8: maximum consecutive hazard-stall cycles before the watchdog trips.
- `DRAIN_CYCLES`, 3: cycles from halt entering EX until it has committed in WB.
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins execution from IDLE.
- `hazard_id`  in  1  RAW hazard on the instruction in ID.
- `branch_taken_ex`  in  1  branch in EX resolved taken.
- `jump_ex`  in  1  jump in EX.
- `halt_id`  in  1  halt decoded in ID.
- `pc_write`  out  1  PC register load enable.
- `ifid_write`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  load a nop into IF/ID.
- `idex_bubble`  out  1  zero the ID/EX control bits (stall bubble).
- `idex_flush`  out  1  zero the ID/EX control bits (redirect).
- `running`  out  1  state is RUN, STALL or DRAIN.
- `halted`  out  1  state is HALTED.
- `stall_err`  out  1  watchdog tripped; sticky.
- `cycle_cnt`  out  32  active cycles, saturating.
- `stall_cnt`  out  16  bubble cycles, saturating.
- `flush_cnt`  out  16  redirect events, saturating.

## Operation
- States: IDLE, RUN, STALL, DRAIN, HALTED.
- Enable outputs are combinational from state and inputs. Counters, state, the stall-run counter and the drain counter are registered.
- Define `redirect = branch_taken_ex | jump_ex`.
- **IDLE:**
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  - `start`=1 moves to RUN.
- **RUN and STALL priority, highest first:**
  1. **redirect:** pc_write=1, ifid_flush=1, idex_flush=1, flush_cnt+1. Next state RUN; stall run counter cleared. This covers a simultaneous hazard_id or halt_id, because the younger instruction is discarded.
  2. **hazard_id:** pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt+1, stall run counter+1. Next state STALL.
  3. **halt_id:** pc_write=0, ifid_flush=1. The halt proceeds into ID/EX normally. The drain counter loads DRAIN_CYCLES and the next state is DRAIN.
  4. **Otherwise:** pc_write=1, ifid_write=1, all flush/bubble=0. Next state RUN; stall run counter cleared.
- **STALL exit:** STALL leaves to RUN in the cycle hazard_id drops. If the stall run counter reaches STALL_LIMIT while hazard_id is still 1, set stall_err and go to HALTED.
- **DRAIN:**
  - pc_write=0, ifid_write=0, ifid_flush=1. branch_taken_ex, jump_ex, hazard_id, halt_id and start are ignored.
  - The drain counter decrements each cycle. At 1, the next state is HALTED.
- **HALTED:**
  - All enables 0; ifid_flush=1, idex_flush=1. Counters frozen.
  - Exit only via reset; start is ignored.
- **Counters:**
  - cycle_cnt increments every cycle in RUN, STALL or DRAIN.
  - All counters saturate at all-ones and never wrap.

## Timing
- **Reset values, asynchronous on `reset`=0:**
  - state IDLE; all counters 0; stall_err=0; running=0; halted=0.
  - pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=1, idex_flush=1.
- **Reset mid-operation:** aborts any state immediately to IDLE with the values above.
- **start latency:** asserting start in IDLE gives RUN on the next edge, with pc_write=1 in that cycle.
- **Redirect:** flush outputs appear in the same cycle as branch_taken_ex/jump_ex; no added latency.
- **Halt:**
  - Halt seen in ID at cycle N gives DRAIN at N+1 and HALTED at N+1+DRAIN_CYCLES.
  - halted=1 from that cycle on.
- **Watchdog:** hazard_id held continuously from cycle N trips the watchdog. stall_err=1 and HALTED both take effect at edge N+STALL_LIMIT.

## Test plan
- **Start:** reset low for 2 cycles, release, start=1 → running=1 next cycle; pc_write=1, ifid_write=1; cycle_cnt=1 after one RUN cycle.
- **Single stall:** hazard_id=1 for 2 cycles in RUN → pc_write=0, ifid_write=0, idex_bubble=1 for exactly 2 cycles; stall_cnt=2; RUN resumes.
- **Redirect priority:** branch_taken_ex=1, hazard_id=1 and halt_id=1 in the same cycle → pc_write=1, ifid_flush=1, idex_flush=1, idex_bubble=0; flush_cnt=1; state stays RUN and no drain starts.
- **Halt drain:** halt_id=1 at cycle 10 → DRAIN cycles 11–13 with pc_write=0; halted=1 at cycle 14; jump_ex=1 at cycle 12 is ignored; cycle_cnt freezes afterwards.
- **Watchdog:** hazard_id held high with STALL_LIMIT=8 → stall_err=1 and halted=1 after 8 edges; stall_cnt=8.
- **Async reset in DRAIN:** reset=0 mid-DRAIN with no clock edge → all outputs at reset values immediately; counters read 0.

Source files
------------

// File: rtl/pipeline_control.sv
// Pipeline sequencer: drives stage enables, flushes and bubbles, drains the
// pipeline on halt, bounds hazard stalls with a watchdog and keeps counters.
module pipeline_control #(
    parameter int STALL_LIMIT  = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hazard_id,
    input  logic        branch_taken_ex,
    input  logic        jump_ex,
    input  logic        halt_id,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        idex_flush,
    output logic        running,
    output logic        halted,
    output logic        stall_err,
    output logic [31:0] cycle_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STALL,
        DRAIN,
        HALTED
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] stall_run, stall_run_next, stall_run_inc;
    logic [DW-1:0] drain_cnt, drain_cnt_next;
    logic          inc_stall, inc_flush, trip;
    logic          redirect;

    assign redirect      = branch_taken_ex | jump_ex;
    assign stall_run_inc = stall_run + SW'(1);
    assign running       = (state == RUN) || (state == STALL) || (state == DRAIN);
    assign halted        = (state == HALTED);

    always_comb begin
        state_next     = state;
        stall_run_next = stall_run;
        drain_cnt_next = drain_cnt;
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        idex_flush     = 1'b0;
        inc_stall      = 1'b0;
        inc_flush      = 1'b0;
        trip           = 1'b0;
        case (state)
            IDLE: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (start) state_next = RUN;
            end
            RUN, STALL: begin
                // A redirect discards the younger instruction, so it outranks hazard and halt.
                if (redirect) begin
                    pc_write       = 1'b1;
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                    inc_flush      = 1'b1;
                    stall_run_next = '0;
                    state_next     = RUN;
                end else if (hazard_id) begin
                    idex_bubble    = 1'b1;
                    inc_stall      = 1'b1;
                    stall_run_next = stall_run_inc;
                    if (stall_run_inc >= SW'(STALL_LIMIT)) begin
                        trip       = 1'b1;
                        state_next = HALTED;
                    end else begin
                        state_next = STALL;
                    end
                end else if (halt_id) begin
                    ifid_flush     = 1'b1;
                    drain_cnt_next = DW'(DRAIN_CYCLES);
                    stall_run_next = '0;
                    state_next     = DRAIN;
                end else begin
                    pc_write       = 1'b1;
                    ifid_write     = 1'b1;
                    stall_run_next = '0;
                    state_next     = RUN;
                end
            end
            DRAIN: begin
                ifid_flush     = 1'b1;
                drain_cnt_next = drain_cnt - DW'(1);
                if (drain_cnt <= DW'(1)) state_next = HALTED;
            end
            HALTED: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stall_run <= '0;
            drain_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_next;
            stall_run <= stall_run_next;
            drain_cnt <= drain_cnt_next;
            if (trip) stall_err <= 1'b1;
        end
    end

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (running && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            if (inc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
            if (inc_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized self-checking bench for pipeline_control against a behavioural
// model of the sequencing rules, plus directed start/stall/redirect/halt/watchdog cases.
module tb_pipeline_control;

    localparam int STALL_LIMIT  = 8;
    localparam int DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        hazard_id = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic        jump_ex = 1'b0;
    logic        halt_id = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush;
    logic        running, halted, stall_err;
    logic [31:0] cycle_cnt;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_control #(
        .STALL_LIMIT (STALL_LIMIT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hazard_id      (hazard_id),
        .branch_taken_ex(branch_taken_ex),
        .jump_ex        (jump_ex),
        .halt_id        (halt_id),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .idex_flush     (idex_flush),
        .running        (running),
        .halted         (halted),
        .stall_err      (stall_err),
        .cycle_cnt      (cycle_cnt),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    // Model phases follow the named operating modes: 0 idle, 1 run, 2 stall, 3 drain, 4 halted.
    int     m_phase, m_run_len, m_drain_left;
    longint m_cycles, m_stalls, m_flushes;
    bit     m_err;

    bit     e_pc, e_wr, e_wr_care, e_iff, e_bub, e_idf;
    int     n_phase, n_run_len, n_drain_left;
    bit     n_err, add_stall, add_flush;

    function automatic longint sat(input longint v, input longint maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic modelReset();
        m_phase = 0; m_run_len = 0; m_drain_left = 0;
        m_cycles = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
    endtask

    task automatic evaluate();
        e_pc = 0; e_wr = 0; e_wr_care = 1; e_iff = 0; e_bub = 0; e_idf = 0;
        n_phase = m_phase; n_run_len = m_run_len; n_drain_left = m_drain_left;
        n_err = m_err; add_stall = 0; add_flush = 0;
        if (m_phase == 0) begin
            e_iff = 1; e_idf = 1;
            if (start) n_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            if (branch_taken_ex || jump_ex) begin
                e_pc = 1; e_iff = 1; e_idf = 1; e_wr_care = 0;
                add_flush = 1; n_phase = 1; n_run_len = 0;
            end else if (hazard_id) begin
                e_bub = 1; add_stall = 1; n_run_len = m_run_len + 1;
                if (n_run_len >= STALL_LIMIT) begin
                    n_phase = 4; n_err = 1;
                end else begin
                    n_phase = 2;
                end
            end else if (halt_id) begin
                e_iff = 1; e_wr_care = 0;
                n_drain_left = DRAIN_CYCLES; n_phase = 3;
            end else begin
                e_pc = 1; e_wr = 1; n_phase = 1; n_run_len = 0;
            end
        end else if (m_phase == 3) begin
            e_iff = 1;
            n_drain_left = m_drain_left - 1;
            if (m_drain_left == 1) n_phase = 4;
        end else begin
            e_iff = 1; e_idf = 1;
        end
    endtask

    task automatic modelCommit();
        if (m_phase >= 1 && m_phase <= 3) m_cycles = sat(m_cycles, 64'hFFFF_FFFF);
        if (add_stall) m_stalls = sat(m_stalls, 64'hFFFF);
        if (add_flush) m_flushes = sat(m_flushes, 64'hFFFF);
        m_phase = n_phase; m_run_len = n_run_len;
        m_drain_left = n_drain_left; m_err = n_err;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        evaluate();
        checkOutput("pc_write", 32'(pc_write), 32'(e_pc));
        if (e_wr_care) checkOutput("ifid_write", 32'(ifid_write), 32'(e_wr));
        checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        checkOutput("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        checkOutput("idex_flush", 32'(idex_flush), 32'(e_idf));
        checkOutput("running", 32'(running), 32'(m_phase >= 1 && m_phase <= 3));
        checkOutput("halted", 32'(halted), 32'(m_phase == 4));
        checkOutput("stall_err", 32'(stall_err), 32'(m_err));
        checkOutput("cycle_cnt", cycle_cnt, m_cycles[31:0]);
        checkOutput("stall_cnt", 32'(stall_cnt), m_stalls[31:0]);
        checkOutput("flush_cnt", 32'(flush_cnt), m_flushes[31:0]);
    endtask

    // Called one time unit after a rising edge; drives inputs, checks mid-cycle, advances one edge.
    task automatic applyStimulus(input bit s, input bit h, input bit b, input bit j, input bit ht);
        start = s; hazard_id = h; branch_taken_ex = b; jump_ex = j; halt_id = ht;
        #3;
        checkAll();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic doReset();
        start = 0; hazard_id = 0; branch_taken_ex = 0; jump_ex = 0; halt_id = 0;
        reset = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        reset = 1;
    endtask

    initial begin
        // Start and basic run
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("cycle_after_first_run", cycle_cnt, 32'd1);

        // Two-cycle stall then resume
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stall_cnt_two", 32'(stall_cnt), 32'd2);

        // Redirect beats hazard and halt together
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("flush_cnt_one", 32'(flush_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("running_after_redirect", 32'(running), 32'd1);

        // Halt drain with an ignored jump in the middle
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("halted_after_drain", 32'(halted), 32'd1);
        checkOutput("cycle_at_halt", cycle_cnt, 32'd10);
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("cycle_frozen", cycle_cnt, 32'd10);

        // Watchdog
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        repeat (STALL_LIMIT) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wd_stall_err", 32'(stall_err), 32'd1);
        checkOutput("wd_halted", 32'(halted), 32'd1);
        checkOutput("wd_stall_cnt", 32'(stall_cnt), 32'(STALL_LIMIT));

        // Asynchronous reset in the middle of a drain
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        #2;
        reset = 0;
        #1;
        checkOutput("ar_pc_write", 32'(pc_write), 32'd0);
        checkOutput("ar_ifid_write", 32'(ifid_write), 32'd0);
        checkOutput("ar_ifid_flush", 32'(ifid_flush), 32'd1);
        checkOutput("ar_idex_bubble", 32'(idex_bubble), 32'd0);
        checkOutput("ar_idex_flush", 32'(idex_flush), 32'd1);
        checkOutput("ar_running", 32'(running), 32'd0);
        checkOutput("ar_cycle_cnt", cycle_cnt, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1;

        // Randomized episodes; some bias hazards high to exercise the watchdog
        for (int ep = 0; ep < 24; ep++) begin
            doReset();
            for (int k = 0; k < 80; k++) begin
                int hz_pct;
                hz_pct = (ep % 4 == 0) ? 92 : 25;
                applyStimulus($urandom_range(0, 99) < 50,
                              $urandom_range(0, 99) < hz_pct,
                              $urandom_range(0, 99) < 8,
                              $urandom_range(0, 99) < 4,
                              $urandom_range(0, 99) < 4);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
